// File: rtl/gemm_pipe_engine.sv
// gemm_pipe_engine: pipelined fixed-point GEMM, result = (alpha*A*B + beta*C) >>> FRAC_BITS.
// One element issued per cycle in row-major order; saturate or wrap on overflow.
module gemm_pipe_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int K          = 4,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                iclk,
    input  logic                                irst,
    input  logic                                istart,
    input  logic                                iabort,
    input  logic                                isat_en,
    input  logic signed [DATA_WIDTH-1:0]        ialpha,
    input  logic signed [DATA_WIDTH-1:0]        ibeta,
    input  logic [M-1:0][K-1:0][DATA_WIDTH-1:0] ia_matrix,
    input  logic [K-1:0][N-1:0][DATA_WIDTH-1:0] ib_matrix,
    input  logic [M-1:0][N-1:0][DATA_WIDTH-1:0] ic_matrix,
    output logic [M-1:0][N-1:0][DATA_WIDTH-1:0] oresult_matrix,
    output logic                                obusy,
    output logic                                odone,
    output logic                                ooverflow
);

    localparam int DW     = DATA_WIDTH;
    localparam int PROD_W = 2 * DW;
    localparam int DOT_W  = 2 * DW + $clog2(K);
    localparam int SUM_W  = DW + DOT_W + 1;
    localparam int IW     = (M > 1) ? $clog2(M) : 1;
    localparam int JW     = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);

    localparam logic signed [SUM_W-1:0] R_MAX =
        {{(SUM_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] R_MIN =
        {{(SUM_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [M-1:0][K-1:0][DW-1:0] a_q;
    logic [K-1:0][N-1:0][DW-1:0] b_q;
    logic [M-1:0][N-1:0][DW-1:0] c_q;
    logic signed [DW-1:0]        alpha_q;
    logic signed [DW-1:0]        beta_q;
    logic                        sat_q;

    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic          drain_q;

    logic                    s1_valid;
    logic signed [DOT_W-1:0] s1_dot;
    logic signed [DW-1:0]    s1_c;
    logic [IW-1:0]           s1_i;
    logic [JW-1:0]           s1_j;

    logic [M-1:0][N-1:0][DW-1:0] res_buf;

    logic                     issue;
    logic                     last_issue;
    logic                     flush;
    logic                     start_job;
    logic signed [PROD_W-1:0] prod;
    logic signed [DOT_W-1:0]  dot_comb;
    logic signed [SUM_W-1:0]  sum_comb;
    logic signed [SUM_W-1:0]  r_comb;
    logic                     ovf_comb;
    logic [DW-1:0]            clip_comb;

    assign last_issue = (i_q == I_LAST) && (j_q == J_LAST);
    assign flush      = iabort &&
                        ((state_q == S_COMPUTE) || (state_q == S_DRAIN));
    assign start_job  = (state_q == S_IDLE) && istart;
    assign obusy      = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    assign odone      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (istart) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (iabort) begin
                    state_d = S_IDLE;
                end else begin
                    issue = 1'b1;
                    if (last_issue) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (iabort)       state_d = S_IDLE;
                else if (drain_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage 1 operand: K parallel multipliers reduced at full precision
    always_comb begin
        prod     = '0;
        dot_comb = '0;
        for (int k = 0; k < K; k++) begin
            prod = PROD_W'($signed(a_q[i_q][k])) *
                   PROD_W'($signed(b_q[k][j_q]));
            dot_comb = dot_comb + DOT_W'(prod);
        end
    end

    always_comb begin
        sum_comb  = SUM_W'(alpha_q) * SUM_W'(s1_dot) +
                    SUM_W'(beta_q) * SUM_W'(s1_c);
        r_comb    = sum_comb >>> FRAC_BITS;
        ovf_comb  = (r_comb > R_MAX) || (r_comb < R_MIN);
        clip_comb = r_comb[DW-1:0];
        if (ovf_comb && sat_q) begin
            clip_comb = (r_comb > R_MAX) ? OUT_MAX : OUT_MIN;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q        <= S_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            alpha_q        <= '0;
            beta_q         <= '0;
            sat_q          <= 1'b0;
            i_q            <= '0;
            j_q            <= '0;
            drain_q        <= 1'b0;
            s1_valid       <= 1'b0;
            s1_dot         <= '0;
            s1_c           <= '0;
            s1_i           <= '0;
            s1_j           <= '0;
            res_buf        <= '0;
            oresult_matrix <= '0;
            ooverflow      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_job) begin
                a_q       <= ia_matrix;
                b_q       <= ib_matrix;
                c_q       <= ic_matrix;
                alpha_q   <= ialpha;
                beta_q    <= ibeta;
                sat_q     <= isat_en;
                i_q       <= '0;
                j_q       <= '0;
                ooverflow <= 1'b0;
            end

            if (issue) begin
                if (j_q == J_LAST) begin
                    j_q <= '0;
                    i_q <= i_q + 1'b1;
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end

            s1_valid <= issue;
            if (issue) begin
                s1_dot <= dot_comb;
                s1_c   <= $signed(c_q[i_q][j_q]);
                s1_i   <= i_q;
                s1_j   <= j_q;
            end

            // Stage 2 lands straight in the result buffer; abort drops it
            if (s1_valid && !flush) begin
                res_buf[s1_i][s1_j] <= clip_comb;
                if (ovf_comb) ooverflow <= 1'b1;
            end

            if (state_q == S_COMPUTE) drain_q <= 1'b0;
            else if (state_q == S_DRAIN) drain_q <= 1'b1;

            if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
                oresult_matrix <= res_buf;
            end
        end
    end

endmodule

// File: tb/tb_gemm_pipe_engine.sv
// tb_gemm_pipe_engine: directed checks of the 4x4x4 GEMM engine.
// Latency counts the istart sampling edge as edge 1; odone must rise at edge 19.
module tb_gemm_pipe_engine;

    typedef logic [3:0][3:0][15:0] mat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        istart;
    logic        iabort;
    logic        isat_en;
    logic [15:0] alpha;
    logic [15:0] beta;
    mat_t        a_m;
    mat_t        b_m;
    mat_t        c_m;
    mat_t        res;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    gemm_pipe_engine #(
        .DATA_WIDTH(16),
        .M(4),
        .N(4),
        .K(4),
        .FRAC_BITS(8)
    ) dut (
        .iclk(clk),
        .irst(rst),
        .istart(istart),
        .iabort(iabort),
        .isat_en(isat_en),
        .ialpha(alpha),
        .ibeta(beta),
        .ia_matrix(a_m),
        .ib_matrix(b_m),
        .ic_matrix(c_m),
        .oresult_matrix(res),
        .obusy(busy),
        .odone(done),
        .ooverflow(ovf)
    );

    always #5 clk = ~clk;

    function automatic mat_t fill(input logic [15:0] v);
        mat_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = v;
        return m;
    endfunction

    task automatic setup(input mat_t a, input mat_t b, input mat_t c,
                         input logic [15:0] al, input logic [15:0] be,
                         input logic sat);
        a_m     = a;
        b_m     = b;
        c_m     = c;
        alpha   = al;
        beta    = be;
        isat_en = sat;
    endtask

    task automatic run_job(output int lat, output bit to);
        @(negedge clk);
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        lat = 0;
        to  = 1'b1;
        for (int e = 2; e <= 40; e++) begin
            @(negedge clk);
            if (done) begin
                lat = e;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_tests++;
        if (res !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold got res=%h busy=%b done=%b ovf=%b exp 0",
                     res, busy, done, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (res !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got res=%h busy=%b done=%b ovf=%b exp 0",
                     res, busy, done, ovf);
        end
    endtask

    task automatic test_identity();
        int   lat;
        bit   to;
        mat_t a;
        mat_t b;
        a = fill(16'd0);
        for (int i = 0; i < 4; i++) a[i][i] = 16'd1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                b[i][j] = 16'(i * 4 + j + 1);
        setup(a, b, fill(16'd0), 16'd256, 16'd0, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || lat != 19) begin
            n_fail++;
            $display("FAIL identity_latency got %0d (timeout=%0b) exp 19", lat, to);
        end
        n_tests++;
        if (res !== b) begin
            n_fail++;
            $display("FAIL identity_result got %h exp %h", res, b);
        end
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_ovf got %b exp 0", ovf);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_beta_only();
        int lat;
        bit to;
        setup(fill(16'd3), fill(16'd4), fill(16'd5), 16'd0, 16'd512, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'd10)) begin
            n_fail++;
            $display("FAIL beta_only got %h (timeout=%0b) exp all 000a", res, to);
        end
        setup(fill(16'd1), fill(16'd1), fill(16'd9), 16'd128, 16'd0, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'd2)) begin
            n_fail++;
            $display("FAIL alpha_half got %h (timeout=%0b) exp all 0002", res, to);
        end
    endtask

    task automatic test_overflow();
        int lat;
        bit to;
        setup(fill(16'd32767), fill(16'd32767), fill(16'd0),
              16'd256, 16'd0, 1'b1);
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'h7fff) || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sat got %h ovf=%b exp all 7fff ovf=1", res, ovf);
        end
        isat_en = 1'b0;
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'h0004) || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_wrap got %h ovf=%b exp all 0004 ovf=1", res, ovf);
        end
    endtask

    task automatic test_signed();
        int lat;
        bit to;
        setup(fill(16'hffff), fill(16'd2), fill(16'hfffd),
              16'd256, 16'd256, 1'b1);
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'hfff5) || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_mix got %h ovf=%b exp all fff5 ovf=0", res, ovf);
        end
        setup(fill(16'hffff), fill(16'd1), fill(16'd0),
              16'd128, 16'd0, 1'b1);
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'hfffe)) begin
            n_fail++;
            $display("FAIL signed_half got %h exp all fffe", res);
        end
    endtask

    task automatic test_floor();
        int lat;
        bit to;
        setup(fill(16'd1), fill(16'd1), fill(16'd0), 16'd1, 16'd0, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'd0)) begin
            n_fail++;
            $display("FAIL floor_pos got %h exp all 0000", res);
        end
        alpha = 16'hffff;
        run_job(lat, to);
        n_tests++;
        if (to || res !== fill(16'hffff)) begin
            n_fail++;
            $display("FAIL floor_neg got %h exp all ffff", res);
        end
    endtask

    task automatic test_abort();
        int lat;
        bit to;
        bit seen;
        setup(fill(16'd0), fill(16'd0), fill(16'd5), 16'd0, 16'd512, 1'b0);
        run_job(lat, to);
        setup(fill(16'hffff), fill(16'd2), fill(16'hfffd),
              16'd256, 16'd256, 1'b0);
        @(negedge clk);
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before got %b exp 1", busy);
        end
        iabort = 1'b1;
        @(negedge clk);
        iabort = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy_after got %b exp 0", busy);
        end
        seen = 1'b0;
        for (int e = 0; e < 25; e++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_tests++;
        if (seen || res !== fill(16'd10)) begin
            n_fail++;
            $display("FAIL abort_hold got res=%h done_seen=%b exp all 000a 0",
                     res, seen);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        setup(fill(16'hffff), fill(16'd2), fill(16'hfffd),
              16'd256, 16'd256, 1'b0);
        @(negedge clk);
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        a_m   = fill(16'd7);
        c_m   = fill(16'd100);
        alpha = 16'd1;
        lat = 0;
        for (int e = 2; e <= 40; e++) begin
            @(negedge clk);
            istart = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
            if (e == 4 || e == 10 || e == 17) istart = 1'b1;
        end
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        n_tests++;
        if (lat != 19) begin
            n_fail++;
            $display("FAIL ignore_latency got %0d exp 19", lat);
        end
        n_tests++;
        if (res !== fill(16'hfff5)) begin
            n_fail++;
            $display("FAIL ignore_snapshot got %h exp all fff5", res);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_in_done got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_midjob();
        int lat;
        bit to;
        setup(fill(16'd32767), fill(16'd32767), fill(16'd0),
              16'd256, 16'd0, 1'b0);
        @(negedge clk);
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
        repeat (7) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL midjob_pre got busy=%b ovf=%b exp 1 1", busy, ovf);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (res !== '0 || busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midjob_reset got res=%h busy=%b ovf=%b exp 0",
                     res, busy, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        setup(fill(16'hffff), fill(16'd1), fill(16'd0),
              16'd128, 16'd0, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || lat != 19 || res !== fill(16'hfffe)) begin
            n_fail++;
            $display("FAIL after_reset got %h lat=%0d exp all fffe lat=19",
                     res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        setup(fill(16'd0), fill(16'd0), fill(16'd5), 16'd0, 16'd512, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || lat != 19 || res !== fill(16'd10)) begin
            n_fail++;
            $display("FAIL b2b_first got %h lat=%0d exp all 000a lat=19",
                     res, lat);
        end
        setup(fill(16'd1), fill(16'd1), fill(16'd0), 16'd128, 16'd0, 1'b0);
        run_job(lat, to);
        n_tests++;
        if (to || lat != 19 || res !== fill(16'd2)) begin
            n_fail++;
            $display("FAIL b2b_second got %h lat=%0d exp all 0002 lat=19",
                     res, lat);
        end
    endtask

    initial begin
        istart  = 1'b0;
        iabort  = 1'b0;
        isat_en = 1'b0;
        alpha   = '0;
        beta    = '0;
        a_m     = '0;
        b_m     = '0;
        c_m     = '0;
        test_reset();
        test_identity();
        test_beta_only();
        test_overflow();
        test_signed();
        test_floor();
        test_abort();
        test_start_ignored();
        test_reset_midjob();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
